// File: rtl/alu_logic_stage.sv
// alu_logic_stage: registered 64-bit AND/OR/XOR/XNOR execute stage feeding a valid/ready result FIFO.
// Optional build macro ALU_LOGIC_FLAGS_EN adds out_zero/out_parity, captured at push and queued with c.

module and_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bit
      assign y[gi] = a[gi] & b[gi];
    end
  endgenerate
endmodule

module or_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bit
      assign y[gi] = a[gi] | b[gi];
    end
  endgenerate
endmodule

module xor_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bit
      assign y[gi] = a[gi] ^ b[gi];
    end
  endgenerate
endmodule

module alu_logic_stage #(
  parameter int WIDTH     = 64,
  parameter int TAG_W     = 5,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_LOGIC_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic             busy
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(OUT_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [TAG_W-1:0] tag_reg;

  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;

  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;
  logic [WIDTH-1:0] result;

  logic             accept;
  logic             push;
  logic             pop;
  logic             head_valid;

  logic [WIDTH-1:0] mem_data [OUT_DEPTH];
  logic [TAG_W-1:0] mem_tag  [OUT_DEPTH];
  logic [WIDTH-1:0] hold_data_reg;
  logic [TAG_W-1:0] hold_tag_reg;

`ifdef ALU_LOGIC_FLAGS_EN
  logic             mem_zero   [OUT_DEPTH];
  logic             mem_parity [OUT_DEPTH];
  logic             hold_zero_reg;
  logic             hold_parity_reg;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Readiness looks only at registered occupancy, so a push can never find the FIFO full.
  assign in_ready   = ({1'b0, count_reg} + {{CW{1'b0}}, s1_valid_reg}) < DEPTH_V;
  assign accept     = in_valid & in_ready;
  assign push       = s1_valid_reg;
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid & out_ready;
  assign out_valid  = head_valid;
  assign busy       = s1_valid_reg | head_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      tag_reg      <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        op_reg  <= op;
        tag_reg <= in_tag;
      end
    end
  end

  and_64bit u_and (.a(a_reg), .b(b_reg), .y(and_y));
  or_64bit  u_or  (.a(a_reg), .b(b_reg), .y(or_y));
  xor_64bit u_xor (.a(a_reg), .b(b_reg), .y(xor_y));

  always_comb begin
    result = and_y;
    case (op_reg)
      2'b00: result = and_y;
      2'b01: result = or_y;
      2'b10: result = xor_y;
      2'b11: result = ~xor_y;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  // Storage carries no reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= result;
      mem_tag[wr_ptr_reg]  <= tag_reg;
`ifdef ALU_LOGIC_FLAGS_EN
      mem_zero[wr_ptr_reg]   <= (result == '0);
      mem_parity[wr_ptr_reg] <= ^result;
`endif
    end
  end

  // Shadow of the presented head so outputs keep their last value once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data_reg <= '0;
      hold_tag_reg  <= '0;
    end else if (head_valid) begin
      hold_data_reg <= mem_data[rd_ptr_reg];
      hold_tag_reg  <= mem_tag[rd_ptr_reg];
    end
  end

  assign c       = head_valid ? mem_data[rd_ptr_reg] : hold_data_reg;
  assign out_tag = head_valid ? mem_tag[rd_ptr_reg]  : hold_tag_reg;

`ifdef ALU_LOGIC_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_zero_reg   <= 1'b0;
      hold_parity_reg <= 1'b0;
    end else if (head_valid) begin
      hold_zero_reg   <= mem_zero[rd_ptr_reg];
      hold_parity_reg <= mem_parity[rd_ptr_reg];
    end
  end

  assign out_zero   = head_valid ? mem_zero[rd_ptr_reg]   : hold_zero_reg;
  assign out_parity = head_valid ? mem_parity[rd_ptr_reg] : hold_parity_reg;
`endif

endmodule

// File: tb/tb_alu_logic_stage.sv
// tb_alu_logic_stage: randomized self-checking bench for alu_logic_stage against a queue-based reference.
// Flag checks are included when ALU_LOGIC_FLAGS_EN is defined.

`define CYCLE_CHECKS \
  total++; \
  if (in_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL %s in_ready got=%b want=%b cyc=%0d", tname, in_ready, (q.size() < DEPTH), cyc); end \
  total++; \
  if (out_valid !== exp_vld()) begin bad++; $display("FAIL %s out_valid got=%b want=%b cyc=%0d", tname, out_valid, exp_vld(), cyc); end \
  total++; \
  if (busy !== (q.size() != 0)) begin bad++; $display("FAIL %s busy got=%b want=%b cyc=%0d", tname, busy, (q.size() != 0), cyc); end \
  if (out_valid && out_ready && q.size() > 0) begin \
    total++; \
    if (c !== q[0].res || out_tag !== q[0].tag) begin bad++; $display("FAIL %s result got=%h/%0d want=%h/%0d cyc=%0d", tname, c, out_tag, q[0].res, q[0].tag, cyc); end \
    else $display("%s: pop c=%h tag=%0d cyc=%0d", tname, c, out_tag, cyc); \
  end

module tb_alu_logic_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c;
  logic [4:0]  out_tag;
  logic        busy;
`ifdef ALU_LOGIC_FLAGS_EN
  logic        out_zero;
  logic        out_parity;
`endif

  alu_logic_stage #(.WIDTH(64), .TAG_W(5), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .out_tag(out_tag),
`ifdef ALU_LOGIC_FLAGS_EN
    .out_zero(out_zero), .out_parity(out_parity),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          k;
  } item_t;

  // Every accepted bundle not yet popped, in acceptance order; k is the edge that accepted it.
  item_t q[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  string tname = "init";

  function automatic logic [63:0] ref_op(input logic [63:0] x, input logic [63:0] y, input logic [1:0] sel);
    case (sel)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  // A result becomes visible one edge after the edge that accepted it.
  function automatic bit exp_vld();
    return (q.size() > 0) && (q[0].k + 1 <= cyc);
  endfunction

  task automatic advance();
    bit    acc;
    bit    pp;
    item_t it;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (pp && q.size() > 0) q.delete(0);
    if (acc) begin
      it.res = ref_op(a, b, op);
      it.tag = in_tag;
      it.k   = cyc + 1;
      q.push_back(it);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    a = '0; b = '0; op = '0; in_tag = '0;
  endtask

  task automatic test_reset();
    tname = "reset";
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
    total++; if (c !== 64'h0) begin bad++; $display("FAIL reset c got=%h want=0", c); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset out_tag got=%0d want=0", out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
    $display("reset: out_valid=%b c=%h in_ready=%b busy=%b", out_valid, c, in_ready, busy);
    rst = 1'b0;
  endtask

  task automatic test_ops();
    int tag_n = 0;
    int tries;
    bit done;
    tname = "ops";
    for (int i = 0; i < 64; i++) begin
      for (int o = 0; o < 4; o++) begin
        for (int bs = 0; bs < 2; bs++) begin
          tries = 0;
          done = 1'b0;
          while (!done) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 64'h1 << i;
            b = bs ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
            op = 2'(o);
            in_tag = 5'(tag_n);
            out_ready = 1'b1;
            `CYCLE_CHECKS
            done = in_ready;
            advance();
            tries++;
            if (!done && tries > 8) begin
              total++; bad++;
              $display("FAIL ops accept_timeout got=stalled want=accepted i=%0d op=%0d", i, o);
              done = 1'b1;
            end
          end
          tag_n++;
        end
      end
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      @(negedge clk);
      idle_inputs();
      `CYCLE_CHECKS
      advance();
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL ops drain got=%0d left want=0", q.size()); end
  endtask

  task automatic test_latency();
    tname = "latency";
    @(negedge clk);
    in_valid = 1'b1; a = 64'hF0F0_F0F0_F0F0_F0F0; b = 64'hFF00_FF00_FF00_FF00; op = 2'd2; in_tag = 5'd9;
    out_ready = 1'b1;
    `CYCLE_CHECKS
    advance();
    @(negedge clk);
    idle_inputs();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency early_valid got=%b want=0", out_valid); end
    `CYCLE_CHECKS
    advance();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency valid got=%b want=1", out_valid); end
    total++; if (c !== 64'h0FF0_0FF0_0FF0_0FF0) begin bad++; $display("FAIL latency c got=%h want=0ff00ff00ff00ff0", c); end
    total++; if (out_tag !== 5'd9) begin bad++; $display("FAIL latency tag got=%0d want=9", out_tag); end
    `CYCLE_CHECKS
    advance();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency late_valid got=%b want=0", out_valid); end
    total++; if (c !== 64'h0FF0_0FF0_0FF0_0FF0) begin bad++; $display("FAIL latency hold_c got=%h want=0ff00ff00ff00ff0", c); end
    `CYCLE_CHECKS
    advance();
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int popped = 0;
    bit fresh = 1'b1;
    tname = "backpressure";
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (fresh) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op = 2'($urandom_range(0, 3)); in_tag = 5'($urandom_range(0, 31));
      end
      out_ready = 1'b0;
      `CYCLE_CHECKS
      fresh = in_ready;
      if (in_ready) accepted++;
      advance();
    end
    total++; if (accepted != DEPTH) begin bad++; $display("FAIL backpressure accepted got=%0d want=%0d", accepted, DEPTH); end
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL backpressure in_ready got=%b want=0", in_ready); end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      if (n > 0) @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      `CYCLE_CHECKS
      if (out_valid) popped++;
      advance();
    end
    total++; if (popped != DEPTH) begin bad++; $display("FAIL backpressure popped got=%0d want=%0d", popped, DEPTH); end
  endtask

  task automatic test_streaming();
    int accepted = 0;
    int popped = 0;
    bit fresh = 1'b1;
    tname = "stream";
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      op = 2'($urandom_range(0, 3)); in_tag = 5'(n);
      out_ready = 1'b1;
      `CYCLE_CHECKS
      if (in_ready) accepted++;
      if (out_valid) popped++;
      advance();
    end
    total++; if (accepted != 100) begin bad++; $display("FAIL stream accepted got=%0d want=100", accepted); end
    total++; if (popped != 98) begin bad++; $display("FAIL stream popped_in_window got=%0d want=98", popped); end
    tname = "random_ready";
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (fresh) begin
        in_valid = ($urandom_range(0, 9) < 8);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op = 2'($urandom_range(0, 3)); in_tag = 5'($urandom_range(0, 31));
      end
      out_ready = $urandom_range(0, 1) == 1;
      `CYCLE_CHECKS
      fresh = !in_valid || in_ready;
      advance();
      total++; if (q.size() > DEPTH) begin bad++; $display("FAIL random_ready occupancy got=%0d want<=%0d", q.size(), DEPTH); end
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      @(negedge clk);
      idle_inputs();
      out_ready = 1'b1;
      `CYCLE_CHECKS
      advance();
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL random_ready drain got=%0d left want=0", q.size()); end
  endtask

  task automatic test_reset_midburst();
    tname = "reset_midburst";
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = {$urandom, $urandom} | 64'h1; b = 64'h0; op = 2'd1; in_tag = 5'(n + 1);
      out_ready = 1'b0;
      `CYCLE_CHECKS
      advance();
    end
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    q.delete();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_midburst out_valid got=%b want=0", out_valid); end
    total++; if (c !== 64'h0) begin bad++; $display("FAIL reset_midburst c got=%h want=0", c); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset_midburst out_tag got=%0d want=0", out_tag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_midburst busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_midburst in_ready got=%b want=1", in_ready); end
    $display("reset_midburst: out_valid=%b c=%h busy=%b", out_valid, c, busy);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'hFFFF_0000_FFFF_0000; op = 2'd0; in_tag = 5'd17;
    out_ready = 1'b1;
    `CYCLE_CHECKS
    advance();
    for (int n = 0; n < 10 && q.size() > 0; n++) begin
      @(negedge clk);
      idle_inputs();
      `CYCLE_CHECKS
      advance();
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL reset_midburst drain got=%0d left want=0", q.size()); end
  endtask

`ifdef ALU_LOGIC_FLAGS_EN
  task automatic test_flags();
    logic [63:0] fa [2];
    logic [63:0] fb [2];
    logic [1:0]  fo [2];
    logic        wz [2];
    logic        wp [2];
    int          waited;
    fa[0] = 64'hAAAA_AAAA_AAAA_AAAA; fb[0] = 64'h5555_5555_5555_5555; fo[0] = 2'd0; wz[0] = 1'b1; wp[0] = 1'b0;
    fa[1] = 64'h1;                   fb[1] = 64'h0;                   fo[1] = 2'd2; wz[1] = 1'b0; wp[1] = 1'b1;
    tname = "flags";
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      in_valid = 1'b1; a = fa[t]; b = fb[t]; op = fo[t]; in_tag = 5'(t);
      out_ready = 1'b0;
      `CYCLE_CHECKS
      advance();
      @(negedge clk);
      idle_inputs();
      waited = 0;
      while (!out_valid && waited < 5) begin
        advance();
        @(negedge clk);
        waited++;
      end
      total++; if (out_zero !== wz[t]) begin bad++; $display("FAIL flags zero[%0d] got=%b want=%b", t, out_zero, wz[t]); end
      total++; if (out_parity !== wp[t]) begin bad++; $display("FAIL flags parity[%0d] got=%b want=%b", t, out_parity, wp[t]); end
      $display("flags[%0d]: c=%h zero=%b parity=%b", t, c, out_zero, out_parity);
      out_ready = 1'b1;
      `CYCLE_CHECKS
      advance();
      out_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_latency();
    test_backpressure();
    test_streaming();
    test_reset_midburst();
`ifdef ALU_LOGIC_FLAGS_EN
    test_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`undef CYCLE_CHECKS
